// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath stages.
// Holds the default field widths, the exponent reference position and the
// payload record that the stage-4 skid register and stage A carry.
// Optional build macro honoured by users of this package: MAC_NORM_STG_ROUND_EN.

package mac_pkg;

    // Default widths of the stage-4 datapath fields.
    localparam int MAC_PSUM_W  = 19;  // two's-complement partial sum
    localparam int MAC_EXP_W   = 6;   // bypassed max exponent
    localparam int MAC_NORM_W  = 11;  // normalised mantissa incl. leading 1
    localparam int MAC_DIFF_W  = 5;   // signed exponent shift
    localparam int MAC_REF_POS = 10;  // psum bit position meaning "no shift"
    localparam int MAC_SIDE_W  = 5;   // Q-fraction sideband

    // One captured input beat: the sum plus the sideband that travels with it.
    typedef struct packed {
        logic [MAC_PSUM_W-1:0] psum;
        logic [MAC_EXP_W-1:0]  max_exp;
        logic [MAC_SIDE_W-1:0] q_frac;
    } mac_payload_t;

endpackage : mac_pkg

// File: rtl/mac_norm_lzd.sv
// Combinational normaliser: absolute value, leading-one detect, left-justify
// into a NORM_W mantissa and signed exponent shift relative to REF_POS.
// Build macro MAC_NORM_STG_ROUND_EN: when defined the mantissa is rounded to
// nearest-even (with renormalisation on overflow); otherwise it is truncated.
// Kept free of handshake logic so other MAC stages can reuse it.

module mac_norm_lzd #(
    parameter int PSUM_W  = 19,
    parameter int NORM_W  = 11,
    parameter int DIFF_W  = 5,
    parameter int REF_POS = 10
) (
    input  logic [PSUM_W-1:0] psum_i,
    output logic [NORM_W-1:0] norm_o,
    output logic [DIFF_W-1:0] exp_diff_o,
    output logic              carry_o,
    output logic              sgn_o,
    output logic              zero_o
);

    logic [PSUM_W-1:0] mag;
    logic [NORM_W-1:0] norm;
    logic              sgn;
    int                lead;
    int                exp_int;
`ifdef MAC_NORM_STG_ROUND_EN
    logic [PSUM_W-1:0] shifted;
    logic [NORM_W:0]   norm_inc;
    logic              guard;
    logic              sticky;
`endif

    // Magnitude, leading-one position, left-justified mantissa and exponent shift.
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        sgn  = psum_i[PSUM_W-1];
        // Unary minus wraps the most-negative sum onto 2^(PSUM_W-1), which is
        // exactly its magnitude when read as unsigned.
        mag  = sgn ? -psum_i : psum_i;
        lead = 0;
        for (int i = 0; i < PSUM_W; i++) begin
            if (mag[i]) lead = i;
        end
`ifdef MAC_NORM_STG_ROUND_EN
        shifted  = mag << (PSUM_W - 1 - lead);
        norm     = shifted[PSUM_W-1 -: NORM_W];
        exp_int  = lead - REF_POS;
        norm_inc = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        // Guard is the first bit below the mantissa, sticky the OR of the rest.
        for (int i = 0; i < PSUM_W; i++) begin
            if (i == PSUM_W - NORM_W - 1) guard = shifted[i];
            if (i <  PSUM_W - NORM_W - 1) sticky = sticky | shifted[i];
        end
        if (guard & (sticky | norm[0])) begin
            norm_inc = {1'b0, norm} + {{NORM_W{1'b0}}, 1'b1};
            if (norm_inc[NORM_W]) begin
                // All-ones mantissa rolled over: renormalise one place up.
                norm    = {1'b1, {(NORM_W-1){1'b0}}};
                exp_int = exp_int + 1;
            end else begin
                norm = norm_inc[NORM_W-1:0];
            end
        end
`else
        // Top NORM_W bits of the left-justified magnitude; lower bits drop.
        norm    = NORM_W'((mag << (PSUM_W - 1 - lead)) >> (PSUM_W - NORM_W));
        exp_int = lead - REF_POS;
`endif
        // A zero sum has no leading one: report a clean all-zero result.
        if (mag == '0) begin
            norm    = '0;
            exp_int = 0;
            sgn     = 1'b0;
        end
    end

    assign norm_o     = norm;
    assign exp_diff_o = DIFF_W'(exp_int);
    assign carry_o    = (exp_int > 0);
    assign sgn_o      = sgn;
    assign zero_o     = (mag == '0);

endmodule : mac_norm_lzd

// File: rtl/mac_norm_stg.sv
// MAC stage 4: register and normalise a two's-complement partial sum.
// Input beats pass through a one-entry skid register and stage A (raw payload),
// are normalised combinationally, and land in stage B which drives the outputs.
// Valid/ready on both sides; o_ready is a flop with no path from i_ready.
// Build macro MAC_NORM_STG_ROUND_EN selects round-to-nearest-even mantissas
// (handled inside mac_norm_lzd); by default mantissas are truncated.
// The payload record comes from mac_pkg, so overriding the width parameters
// also requires matching package widths.

module mac_norm_stg
    import mac_pkg::*;
#(
    parameter int PSUM_W  = MAC_PSUM_W,
    parameter int EXP_W   = MAC_EXP_W,
    parameter int NORM_W  = MAC_NORM_W,
    parameter int DIFF_W  = MAC_DIFF_W,
    parameter int REF_POS = MAC_REF_POS,
    parameter int SIDE_W  = MAC_SIDE_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [PSUM_W-1:0] i_psum,
    input  logic [EXP_W-1:0]  i_max_exp,
    input  logic [SIDE_W-1:0] i_Q_frac,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NORM_W-1:0] o_norm_sum,
    output logic [DIFF_W-1:0] o_exp_diff,
    output logic              o_exp_carry,
    output logic              o_sgn,
    output logic              o_zero,
    output logic [EXP_W-1:0]  o_max_exp,
    output logic [SIDE_W-1:0] o_Q_frac
);

    // ------------------------------------------------------------------
    // Handshake state
    // ------------------------------------------------------------------
    mac_payload_t in_payload;
    mac_payload_t skid_q, skid_d;
    mac_payload_t a_q, a_d;
    logic         skid_valid_q, skid_valid_d;
    logic         a_valid_q, a_valid_d;
    logic         ready_q;
    logic         b_valid_q;
    logic         in_fire;
    logic         b_load;
    logic         a_free;

    // Stage B contents, which are also the module outputs.
    logic [NORM_W-1:0] b_norm_q;
    logic [DIFF_W-1:0] b_exp_diff_q;
    logic              b_carry_q;
    logic              b_sgn_q;
    logic              b_zero_q;
    logic [EXP_W-1:0]  b_max_exp_q;
    logic [SIDE_W-1:0] b_q_frac_q;

    // Normaliser results for the beat sitting in stage A.
    logic [NORM_W-1:0] n_norm;
    logic [DIFF_W-1:0] n_exp_diff;
    logic              n_carry;
    logic              n_sgn;
    logic              n_zero;

    assign in_payload.psum    = i_psum;
    assign in_payload.max_exp = i_max_exp;
    assign in_payload.q_frac  = i_Q_frac;

    // o_ready mirrors an empty skid register, so the input can only fire
    // while the skid has room for one beat that A cannot take.
    assign in_fire = i_valid & ready_q;
    // B takes a new beat when it is empty or its current beat leaves this cycle.
    assign b_load  = ~b_valid_q | i_ready;
    // A can take a beat when it is empty or its beat moves into B.
    assign a_free  = ~a_valid_q | b_load;

    // Next state of the skid register and stage A; the skid always drains first.
    always_comb begin
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        a_d          = a_q;
        a_valid_d    = a_valid_q;
        if (a_free) begin
            if (skid_valid_q) begin
                // o_ready is low here, so no new beat competes with the skid.
                a_d          = skid_q;
                a_valid_d    = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                a_d       = in_payload;
                a_valid_d = 1'b1;
            end else begin
                a_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // A is stuck behind a stalled B: park the beat in the skid.
            skid_d       = in_payload;
            skid_valid_d = 1'b1;
        end
    end

    // Skid register, stage A and the registered ready flag.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            a_q          <= '0;
            a_valid_q    <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            a_q          <= a_d;
            a_valid_q    <= a_valid_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Normalise between stage A and stage B
    // ------------------------------------------------------------------
    mac_norm_lzd #(
        .PSUM_W  (PSUM_W),
        .NORM_W  (NORM_W),
        .DIFF_W  (DIFF_W),
        .REF_POS (REF_POS)
    ) u_lzd (
        .psum_i     (a_q.psum),
        .norm_o     (n_norm),
        .exp_diff_o (n_exp_diff),
        .carry_o    (n_carry),
        .sgn_o      (n_sgn),
        .zero_o     (n_zero)
    );

    // Stage B: output valid and the registered normalise result with sideband.
    // NOTE: data registers are reset too, because outputs must read zero during reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            b_valid_q    <= 1'b0;
            b_norm_q     <= '0;
            b_exp_diff_q <= '0;
            b_carry_q    <= 1'b0;
            b_sgn_q      <= 1'b0;
            b_zero_q     <= 1'b0;
            b_max_exp_q  <= '0;
            b_q_frac_q   <= '0;
        end else if (b_load) begin
            b_valid_q <= a_valid_q;
            // Data only moves with a real beat, so a drained B keeps its last values.
            if (a_valid_q) begin
                b_norm_q     <= n_norm;
                b_exp_diff_q <= n_exp_diff;
                b_carry_q    <= n_carry;
                b_sgn_q      <= n_sgn;
                b_zero_q     <= n_zero;
                b_max_exp_q  <= a_q.max_exp;
                b_q_frac_q   <= a_q.q_frac;
            end
        end
    end

    assign o_ready     = ready_q;
    assign o_valid     = b_valid_q;
    assign o_norm_sum  = b_norm_q;
    assign o_exp_diff  = b_exp_diff_q;
    assign o_exp_carry = b_carry_q;
    assign o_sgn       = b_sgn_q;
    assign o_zero      = b_zero_q;
    assign o_max_exp   = b_max_exp_q;
    assign o_Q_frac    = b_q_frac_q;

endmodule : mac_norm_stg

// File: tb/tb_mac_norm_stg.sv
// Self-checking bench for mac_norm_stg.
// Directed beats from the test plan, a stalled 8-beat stream, a mid-stream
// reset and a randomized valid/ready section, all scored against an
// arithmetic reference model. Honours MAC_NORM_STG_ROUND_EN like the RTL.

module tb_mac_norm_stg;

    localparam int PSUM_W  = 19;
    localparam int EXP_W   = 6;
    localparam int NORM_W  = 11;
    localparam int DIFF_W  = 5;
    localparam int REF_POS = 10;
    localparam int SIDE_W  = 5;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_valid;
    logic              o_ready;
    logic [PSUM_W-1:0] i_psum;
    logic [EXP_W-1:0]  i_max_exp;
    logic [SIDE_W-1:0] i_Q_frac;
    logic              o_valid;
    logic              i_ready;
    logic [NORM_W-1:0] o_norm_sum;
    logic [DIFF_W-1:0] o_exp_diff;
    logic              o_exp_carry;
    logic              o_sgn;
    logic              o_zero;
    logic [EXP_W-1:0]  o_max_exp;
    logic [SIDE_W-1:0] o_Q_frac;

    mac_norm_stg #(
        .PSUM_W  (PSUM_W),
        .EXP_W   (EXP_W),
        .NORM_W  (NORM_W),
        .DIFF_W  (DIFF_W),
        .REF_POS (REF_POS),
        .SIDE_W  (SIDE_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_psum      (i_psum),
        .i_max_exp   (i_max_exp),
        .i_Q_frac    (i_Q_frac),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_norm_sum  (o_norm_sum),
        .o_exp_diff  (o_exp_diff),
        .o_exp_carry (o_exp_carry),
        .o_sgn       (o_sgn),
        .o_zero      (o_zero),
        .o_max_exp   (o_max_exp),
        .o_Q_frac    (o_Q_frac)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [NORM_W-1:0] norm;
        logic [DIFF_W-1:0] ed;
        logic              carry;
        logic              sgn;
        logic              zero;
        logic [EXP_W-1:0]  me;
        logic [SIDE_W-1:0] qf;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       last_out;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          accept_cyc = 0;
    int          last_lat = -1;
    int          out_cnt  = 0;
    logic        hold_prev = 1'b0;
    logic [30:0] snap;

    // Reference: value of the sum, its magnitude, highest set bit by repeated
    // halving, and the mantissa as an integer shift of the magnitude.
    function automatic beat_t ref_model(logic [PSUM_W-1:0] psum,
                                        logic [EXP_W-1:0] me,
                                        logic [SIDE_W-1:0] qf);
        beat_t r;
        int    v, mag, p, sh, n, e;
`ifdef MAC_NORM_STG_ROUND_EN
        int    rem, half;
`endif
        v     = int'($signed(psum));
        mag   = (v < 0) ? -v : v;
        r.me  = me;
        r.qf  = qf;
        r.sgn = (v < 0);
        r.zero = (mag == 0);
        if (mag == 0) begin
            r.norm  = '0;
            r.ed    = '0;
            r.carry = 1'b0;
            return r;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        sh = p - (NORM_W - 1);
        if (sh > 0) begin
            n = mag >> sh;
`ifdef MAC_NORM_STG_ROUND_EN
            rem  = mag % (1 << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (n % 2) == 1)) n++;
            if (n == (1 << NORM_W)) begin
                n = 1 << (NORM_W - 1);
                p++;
            end
`endif
        end else begin
            n = mag << (-sh);
        end
        e       = p - REF_POS;
        r.norm  = NORM_W'(n);
        r.ed    = DIFF_W'(e);
        r.carry = (e > 0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample on the falling edge, score outputs, record accepts,
    // then return 1 time unit after the rising edge for the next drive.
    task automatic cycle(output logic fired_in);
        beat_t       e;
        logic [30:0] cur;
        @(negedge i_clk);
        cur = {o_valid, o_norm_sum, o_exp_diff, o_exp_carry, o_sgn, o_zero, o_max_exp, o_Q_frac};
        if (hold_prev) check("stall_hold", cur, snap);
        hold_prev = o_valid & ~i_ready;
        snap      = cur;
        if (o_valid && i_ready) begin
            check("spurious_output", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("norm_sum",  o_norm_sum,  e.norm);
                check("exp_diff",  o_exp_diff,  e.ed);
                check("exp_carry", o_exp_carry, e.carry);
                check("sgn",       o_sgn,       e.sgn);
                check("zero",      o_zero,      e.zero);
                check("max_exp",   o_max_exp,   e.me);
                check("q_frac",    o_Q_frac,    e.qf);
            end
            last_out.norm  = o_norm_sum;
            last_out.ed    = o_exp_diff;
            last_out.carry = o_exp_carry;
            last_out.sgn   = o_sgn;
            last_out.zero  = o_zero;
            last_out.me    = o_max_exp;
            last_out.qf    = o_Q_frac;
            last_lat       = cyc - accept_cyc;
            out_cnt++;
        end
        fired_in = i_valid && o_ready;
        if (fired_in) begin
            exp_q.push_back(ref_model(i_psum, i_max_exp, i_Q_frac));
            accept_cyc = cyc;
        end
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    // Run cycles with i_ready high until every expected beat has emerged.
    task automatic drain(input string tag);
        logic f;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle(f);
        check(tag, exp_q.size(), 0);
    endtask

    // Offer one beat on an idle pipe and wait for it to come out.
    task automatic send_one(input logic [PSUM_W-1:0] psum,
                            input logic [EXP_W-1:0] me,
                            input logic [SIDE_W-1:0] qf);
        logic f;
        i_psum    = psum;
        i_max_exp = me;
        i_Q_frac  = qf;
        i_valid   = 1'b1;
        i_ready   = 1'b1;
        cycle(f);
        check("single_accept", f, 1);
        drain("single_drain");
        check("single_latency", last_lat, 2);
    endtask

    logic [PSUM_W-1:0] beats[8];
    int                idx;
    int                base;
    logic              f;

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_psum    = '0;
        i_max_exp = '0;
        i_Q_frac  = '0;

        // Reset state
        #12;
        check("reset_ready", o_ready, 1);
        check("reset_outputs",
              {o_valid, o_norm_sum, o_exp_diff, o_exp_carry, o_sgn, o_zero, o_max_exp, o_Q_frac}, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Directed beats from the test plan
        send_one(19'h00400, 6'h05, 5'h01);
        check("p400_norm", last_out.norm, 11'h400);
        check("p400_ed",   last_out.ed,   5'h00);
        check("p400_carry", last_out.carry, 0);
        check("p400_sgn",  last_out.sgn,  0);
        check("p400_zero", last_out.zero, 0);

        send_one(19'h7FFFF, 6'h11, 5'h02);
        check("m1_norm", last_out.norm, 11'h400);
        check("m1_ed",   last_out.ed,   5'h16);
        check("m1_sgn",  last_out.sgn,  1);

        send_one(19'h40000, 6'h3F, 5'h1F);
        check("mneg_norm",  last_out.norm,  11'h400);
        check("mneg_ed",    last_out.ed,    5'h08);
        check("mneg_carry", last_out.carry, 1);
        check("mneg_sgn",   last_out.sgn,   1);

        send_one(19'h00000, 6'h2A, 5'h13);
        check("zero_flag", last_out.zero, 1);
        check("zero_norm", last_out.norm, 0);
        check("zero_ed",   last_out.ed,   0);
        check("zero_sgn",  last_out.sgn,  0);
        check("zero_me",   last_out.me,   6'h2A);
        check("zero_qf",   last_out.qf,   5'h13);

        send_one(19'h00FFF, 6'h00, 5'h00);
`ifdef MAC_NORM_STG_ROUND_EN
        check("fff_norm",  last_out.norm,  11'h400);
        check("fff_ed",    last_out.ed,    5'h02);
        check("fff_carry", last_out.carry, 1);
`else
        check("fff_norm",  last_out.norm,  11'h7FF);
        check("fff_ed",    last_out.ed,    5'h01);
        check("fff_carry", last_out.carry, 1);
`endif

        // 8-beat stream with a 5-cycle downstream stall
        for (int i = 0; i < 8; i++) beats[i] = PSUM_W'($urandom);
        idx  = 0;
        base = out_cnt;
        for (int k = 0; k < 60 && (idx < 8 || exp_q.size() != 0); k++) begin
            i_ready = !(k >= 2 && k <= 6);
            i_valid = (idx < 8);
            if (idx < 8) begin
                i_psum    = beats[idx];
                i_max_exp = EXP_W'(idx);
                i_Q_frac  = SIDE_W'(idx + 8);
            end
            cycle(f);
            if (f) idx++;
            if (k == 4) begin
                check("stall_ready_low", o_ready, 0);
                check("stall_valid_high", o_valid, 1);
            end
        end
        check("stream_accepted", idx, 8);
        check("stream_count", out_cnt - base, 8);
        drain("stream_drain");

        // Reset in the middle of a stalled stream
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_psum    = PSUM_W'($urandom);
            i_max_exp = EXP_W'($urandom);
            i_Q_frac  = SIDE_W'($urandom);
            cycle(f);
        end
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        check("midrst_ready", o_ready, 1);
        check("midrst_outputs",
              {o_valid, o_norm_sum, o_exp_diff, o_exp_carry, o_sgn, o_zero, o_max_exp, o_Q_frac}, 0);
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        base = out_cnt;
        send_one(19'h01234, 6'h07, 5'h09);
        check("postrst_count", out_cnt - base, 1);

        // Randomized valid/ready traffic with corner-case sums mixed in
        for (int k = 0; k < 400; k++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       i_psum = 19'h00000;
                1:       i_psum = 19'h40000;
                2:       i_psum = 19'h7FFFF;
                3:       i_psum = 19'h3FFFF;
                4:       i_psum = 19'h00FFF;
                5:       i_psum = PSUM_W'($urandom_range(0, 63));
                default: i_psum = PSUM_W'($urandom);
            endcase
            i_max_exp = EXP_W'($urandom);
            i_Q_frac  = SIDE_W'($urandom);
            cycle(f);
        end
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends even if the pipe locks up.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mac_norm_stg
